// File: rtl/pla_sweep_ctrl.sv
// pla_sweep_ctrl: exhaustive input sweep of a single-output netlist pair,
// collecting on-set size, mismatch stats and a MISR signature of y_dut.
module pla_sweep_ctrl #(
  parameter int N_IN   = 20,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_ref,
  input  logic              y_dut,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     onset_cnt,
  output logic [N_IN:0]     mm_cnt,
  output logic [N_IN-1:0]   first_mm,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] RELOAD =
    (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam state_t STEP =
    (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
  localparam logic [N_IN-1:0] X_LAST = '1;
  localparam logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7);
  localparam logic [N_IN:0] ONE = (N_IN+1)'(1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       launch;
  logic       last;
  logic       miss;

  assign launch = start &&
    (state == S_IDLE || state == S_DONE);
  assign last = (x_out == X_LAST);
  assign miss = (y_ref != y_dut);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE,
        S_DONE:   if (start) state_nxt = STEP;
        S_SETTLE: if (cnt == 4'd0) state_nxt = S_SAMPLE;
        S_SAMPLE: state_nxt = last ? S_DONE : STEP;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == S_SETTLE),
      (state == S_SAMPLE): busy = 1'b1;
      (state == S_DONE):   done = 1'b1;
      default: ;
    endcase
  end

  // abort wins over start and over the per-vector updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out     <= '0;
      cnt       <= 4'd0;
      onset_cnt <= '0;
      mm_cnt    <= '0;
      first_mm  <= '0;
      signature <= '1;
    end else if (abort) begin
      x_out <= '0;
    end else if (launch) begin
      x_out     <= '0;
      cnt       <= RELOAD;
      onset_cnt <= '0;
      mm_cnt    <= '0;
      first_mm  <= '0;
      signature <= '1;
    end else if (state == S_SETTLE) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (state == S_SAMPLE) begin
      onset_cnt <= onset_cnt + {{N_IN{1'b0}}, y_dut};
      if (miss) begin
        mm_cnt <= mm_cnt + ONE;
        if (mm_cnt == '0) first_mm <= x_out;
      end
      signature <= {signature[SIG_W-2:0], 1'b0}
        ^ (signature[SIG_W-1] ? POLY : '0)
        ^ {{(SIG_W-1){1'b0}}, y_dut};
      if (!last) begin
        x_out <= x_out + {{(N_IN-1){1'b0}}, 1'b1};
        cnt   <= RELOAD;
      end
    end
  end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb_pla_sweep_ctrl: two 3-input instances (SETTLE=1 and SETTLE=0)
// checked every cycle against a sweep-level reference model.
module tb_pla_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 0, abort_a = 0;
  logic start_b = 0, abort_b = 0;
  int   mode_a = 0, mode_b = 1;

  logic [2:0]  x_a, x_b, fm_a, fm_b;
  logic        yr_a, yd_a, yr_b, yd_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [3:0]  on_a, mm_a, on_b, mm_b;
  logic [31:0] sig_a, sig_b;

  int errors = 0;
  int checks = 0;

  // mode 0: both a&b; mode 1: ref a|b, dut a&b; mode 2: both 1
  function automatic logic f_dut(int m, logic [2:0] v);
    return (m == 2) ? 1'b1 : (v[0] & v[1]);
  endfunction
  function automatic logic f_ref(int m, logic [2:0] v);
    if (m == 2) return 1'b1;
    if (m == 1) return v[0] | v[1];
    return v[0] & v[1];
  endfunction

  assign yd_a = f_dut(mode_a, x_a);
  assign yr_a = f_ref(mode_a, x_a);
  assign yd_b = f_dut(mode_b, x_b);
  assign yr_b = f_ref(mode_b, x_b);

  pla_sweep_ctrl #(.N_IN(3), .SETTLE(1), .SIG_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .x_out(x_a), .y_ref(yr_a), .y_dut(yd_a),
    .busy(busy_a), .done(done_a),
    .onset_cnt(on_a), .mm_cnt(mm_a),
    .first_mm(fm_a), .signature(sig_a));

  pla_sweep_ctrl #(.N_IN(3), .SETTLE(0), .SIG_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .x_out(x_b), .y_ref(yr_b), .y_dut(yd_b),
    .busy(busy_b), .done(done_b),
    .onset_cnt(on_b), .mm_cnt(mm_b),
    .first_mm(fm_b), .signature(sig_b));

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: 0 idle, 1 sweeping, 2 done; t = cycles since start
  int          ms[2], mt[2], mon[2], mmm[2], mfirst[2];
  logic [31:0] msig[2];
  int          per[2] = '{2, 1};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      logic st, ab, yr, yd;
      int   v;
      st = (i == 0) ? start_a : start_b;
      ab = (i == 0) ? abort_a : abort_b;
      if (!rst_n) begin
        ms[i] = 0; mt[i] = 0; mon[i] = 0; mmm[i] = 0; mfirst[i] = 0;
        msig[i] = 32'hFFFFFFFF;
      end else if (ab) begin
        ms[i] = 0;
      end else if (st && ms[i] != 1) begin
        ms[i] = 1; mt[i] = 0; mon[i] = 0; mmm[i] = 0; mfirst[i] = 0;
        msig[i] = 32'hFFFFFFFF;
      end else if (ms[i] == 1) begin
        if (mt[i] % per[i] == per[i] - 1) begin
          v  = mt[i] / per[i];
          yd = f_dut((i == 0) ? mode_a : mode_b, 3'(v));
          yr = f_ref((i == 0) ? mode_a : mode_b, 3'(v));
          mon[i] += int'(yd);
          if (yr != yd) begin
            if (mmm[i] == 0) mfirst[i] = v;
            mmm[i]++;
          end
          msig[i] = {msig[i][30:0], 1'b0}
            ^ (msig[i][31] ? 32'h04C11DB7 : 32'h0)
            ^ {31'b0, yd};
        end
        mt[i]++;
        if (mt[i] == 8 * per[i]) ms[i] = 2;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        int ex;
        ex = (ms[i] == 1) ? mt[i] / per[i] : (ms[i] == 2) ? 7 : 0;
        if (i == 0) begin
          chk("a.x_out", x_a, ex);
          chk("a.busy", busy_a, ms[0] == 1);
          chk("a.done", done_a, ms[0] == 2);
          chk("a.onset", on_a, mon[0]);
          chk("a.mm", mm_a, mmm[0]);
          chk("a.first", fm_a, mfirst[0]);
          chk("a.sig", sig_a, msig[0]);
        end else begin
          chk("b.x_out", x_b, ex);
          chk("b.busy", busy_b, ms[1] == 1);
          chk("b.done", done_b, ms[1] == 2);
          chk("b.onset", on_b, mon[1]);
          chk("b.mm", mm_b, mmm[1]);
          chk("b.first", fm_b, mfirst[1]);
          chk("b.sig", sig_b, msig[1]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(int which);
    if (which == 0) start_a = 1; else start_b = 1;
    tick();
    start_a = 0;
    start_b = 0;
  endtask

  task automatic wait_done(int which, output int cyc);
    cyc = 0;
    while (((which == 0) ? !done_a : !done_b) && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int c;
    logic [31:0] sig1, sig3;
    #12 rst_n = 1'b1;
    tick();
    chk("rst.sig", sig_a, 32'hFFFFFFFF);
    chk("rst.busy", busy_a, 0);

    pulse(0);
    wait_done(0, c);
    chk("s1.latency", c, 16);
    chk("s1.onset", on_a, 2);
    chk("s1.mm", mm_a, 0);
    chk("s1.busy", busy_a, 0);
    sig1 = sig_a;

    pulse(1);
    wait_done(1, c);
    chk("s2.latency", c, 8);
    chk("s2.mm", mm_b, 4);
    chk("s2.first", fm_b, 1);
    chk("s2.onset", on_b, 2);

    mode_b = 2;
    pulse(1);
    wait_done(1, c);
    chk("s3.onset", on_b, 8);
    chk("s3.mm", mm_b, 0);
    sig3 = sig_b;
    pulse(1);
    wait_done(1, c);
    chk("s3.sig_repeat", sig_b, sig3);

    pulse(0);
    repeat (5) tick();
    abort_a = 1;
    start_a = 1;
    tick();
    abort_a = 0;
    start_a = 0;
    chk("ab.busy", busy_a, 0);
    chk("ab.done", done_a, 0);
    chk("ab.x", x_a, 0);
    chk("ab.onset_kept", on_a, 0);
    repeat (3) tick();
    chk("ab.idle", busy_a, 0);

    start_a = 1;
    tick();
    c = 0;
    while (!done_a && c < 100) begin
      start_a = (c < 12) && (c % 3 == 0);
      tick();
      c++;
    end
    start_a = 0;
    chk("s5.latency", c, 16);
    chk("s5.onset", on_a, 2);
    chk("s5.sig", sig_a, sig1);
    pulse(0);
    chk("s5.cleared_on", on_a, 0);
    chk("s5.cleared_sig", sig_a, 32'hFFFFFFFF);
    wait_done(0, c);
    chk("s5.relatency", c, 16);
    chk("s5.resig", sig_a, sig1);
    chk("s5.reonset", on_a, 2);

    pulse(0);
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst.x", x_a, 0);
    chk("rst.busy_mid", busy_a, 0);
    chk("rst.onset", on_a, 0);
    chk("rst.sig_mid", sig_a, 32'hFFFFFFFF);
    chk("rst.b_done", done_b, 0);
    chk("rst.b_onset", on_b, 0);
    #3 rst_n = 1'b1;
    repeat (4) tick();
    chk("rst.idle_busy", busy_a, 0);
    chk("rst.idle_x", x_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
